// File: rtl/dense_layer_seq_pkg.sv
// Shared FSM state type and width helpers for the time-multiplexed dense layer.
// Imported by dense_layer_seq and its MAC unit.
package dense_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MAC,
        BIAS,
        ACT,
        DONE
    } state_e;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // Accumulator holds N_IN full products plus the bias without overflow.
    function automatic int acc_width(input int in_w, input int weight_w, input int n_in);
        return in_w + weight_w + clog2(n_in) + 1;
    endfunction

    function automatic int idx_width(input int count);
        return (count > 1) ? clog2(count) : 1;
    endfunction

endpackage

// File: rtl/dense_layer_seq_if.sv
// Load/done handshake and vector buses between a dense layer and whatever feeds it.
// The master drives load and x_in; the layer (slave) drives busy, done and y_out.
interface dense_layer_seq_if #(
    parameter int N_IN  = 20,
    parameter int N_OUT = 10,
    parameter int IN_W  = 32,
    parameter int OUT_W = 32
);
    logic                   load;
    logic [N_IN*IN_W-1:0]   x_in;
    logic                   busy;
    logic                   done;
    logic [N_OUT*OUT_W-1:0] y_out;

    modport master (
        output load,
        output x_in,
        input  busy,
        input  done,
        input  y_out
    );

    modport slave (
        input  load,
        input  x_in,
        output busy,
        output done,
        output y_out
    );
endinterface

// File: rtl/dense_layer_seq_mac_unit.sv
// Signed multiply-accumulate with synchronous clear and bias-add controls.
// Clear has priority over MAC, MAC over bias add.
module dense_mac_unit #(
    parameter int IN_W     = 32,
    parameter int WEIGHT_W = 8,
    parameter int BIAS_W   = 8,
    parameter int ACC_W    = 46
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    mac_en_i,
    input  logic                    bias_en_i,
    input  logic [IN_W-1:0]         x_i,
    input  logic [WEIGHT_W-1:0]     w_i,
    input  logic [BIAS_W-1:0]       b_i,
    output logic signed [ACC_W-1:0] acc_o
);
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] xExt;
    logic signed [ACC_W-1:0] wExt;
    logic signed [ACC_W-1:0] bExt;

    assign xExt = ACC_W'($signed(x_i));
    assign wExt = ACC_W'($signed(w_i));
    assign bExt = ACC_W'($signed(b_i));

    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (mac_en_i) begin
            acc_d = acc_q + xExt * wExt;
        end else if (bias_en_i) begin
            acc_d = acc_q + bExt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;
endmodule

// File: rtl/dense_layer_seq.sv
// Fully-connected layer y = leaky_relu(W*x + b) computed by one time-multiplexed MAC.
// Define DENSE_SAT_EN to clamp outputs to the OUT_W range instead of wrapping.
module dense_layer_seq
    import dense_pkg::*;
#(
    parameter int N_IN        = 20,
    parameter int N_OUT       = 10,
    parameter int IN_W        = 32,
    parameter int WEIGHT_W    = 8,
    parameter int BIAS_W      = 8,
    parameter int OUT_W       = 32,
    parameter int LEAKY_SHIFT = 3,
    // ROM images: weight word j*N_IN+i and bias word j sit at that index times the word width.
    parameter logic [N_OUT*N_IN*WEIGHT_W-1:0] WEIGHT_INIT = '0,
    parameter logic [N_OUT*BIAS_W-1:0]        BIAS_INIT   = '0
) (
    input logic         clk,
    input logic         reset,
    dense_layer_seq_if.slave layer
);
    localparam int ACC_W = acc_width(IN_W, WEIGHT_W, N_IN);
    localparam int IW    = idx_width(N_IN);
    localparam int JW    = idx_width(N_OUT);
    localparam int NW    = (ACC_W > OUT_W) ? ACC_W : OUT_W;
    localparam logic [IW-1:0] LAST_I = IW'(N_IN - 1);
    localparam logic [JW-1:0] LAST_J = JW'(N_OUT - 1);

    state_e                 state_q;
    state_e                 state_d;
    logic [IW-1:0]          i_q;
    logic [IW-1:0]          i_d;
    logic [JW-1:0]          j_q;
    logic [JW-1:0]          j_d;
    logic [N_IN*IN_W-1:0]   x_q;
    logic [N_OUT*OUT_W-1:0] buf_q;
    logic [N_OUT*OUT_W-1:0] buf_d;
    logic [N_OUT*OUT_W-1:0] y_q;

    logic                    busy;
    logic                    done;
    logic                    macClear;
    logic                    macEn;
    logic                    biasEn;
    int                      wIdx;
    logic [IN_W-1:0]         xSel;
    logic [WEIGHT_W-1:0]     wSel;
    logic [BIAS_W-1:0]       bSel;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] actVal;
    logic signed [NW-1:0]    actWide;
    logic [OUT_W-1:0]        narrowed;

    assign wIdx = int'(j_q) * N_IN + int'(i_q);
    assign xSel = x_q[int'(i_q)*IN_W +: IN_W];
    assign wSel = WEIGHT_INIT[wIdx*WEIGHT_W +: WEIGHT_W];
    assign bSel = BIAS_INIT[int'(j_q)*BIAS_W +: BIAS_W];

    dense_mac_unit #(
        .IN_W     (IN_W),
        .WEIGHT_W (WEIGHT_W),
        .BIAS_W   (BIAS_W),
        .ACC_W    (ACC_W)
    ) u_mac (
        .clk_i     (clk),
        .rst_ni    (reset),
        .clear_i   (macClear),
        .mac_en_i  (macEn),
        .bias_en_i (biasEn),
        .x_i       (xSel),
        .w_i       (wSel),
        .b_i       (bSel),
        .acc_o     (acc)
    );

    assign actVal  = (acc >= 0) ? acc : (acc >>> LEAKY_SHIFT);
    assign actWide = NW'(actVal);

`ifdef DENSE_SAT_EN
    localparam logic signed [NW-1:0] SAT_MAX = {{(NW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [NW-1:0] SAT_MIN = {{(NW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    always_comb begin
        narrowed = OUT_W'(actWide);
        if (actWide > SAT_MAX) begin
            narrowed = SAT_MAX[OUT_W-1:0];
        end else if (actWide < SAT_MIN) begin
            narrowed = SAT_MIN[OUT_W-1:0];
        end
    end
`else
    assign narrowed = OUT_W'(actWide);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        case (state_q)
            IDLE: begin
                if (layer.load) begin
                    state_d = MAC;
                    i_d     = '0;
                    j_d     = '0;
                end
            end
            MAC: begin
                if (i_q == LAST_I) begin
                    state_d = BIAS;
                    i_d     = '0;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            BIAS: state_d = ACT;
            ACT: begin
                if (j_q == LAST_J) begin
                    state_d = DONE;
                    j_d     = '0;
                end else begin
                    state_d = MAC;
                    j_d     = j_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The accumulator stays cleared outside MAC/BIAS, so leaving ACT starts the next neuron at zero.
    always_comb begin
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
        macEn    = (state_q == MAC);
        biasEn   = (state_q == BIAS);
        macClear = !(macEn || biasEn);
    end

    always_comb begin
        buf_d = buf_q;
        if (state_q == ACT) begin
            buf_d[int'(j_q)*OUT_W +: OUT_W] = narrowed;
        end
    end

    // y_out is loaded from the finished buffer on the edge into DONE and held otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q   <= '0;
            buf_q <= '0;
            y_q   <= '0;
        end else begin
            if (state_q == IDLE && layer.load) begin
                x_q <= layer.x_in;
            end
            buf_q <= buf_d;
            if (state_q == ACT && j_q == LAST_J) begin
                y_q <= buf_d;
            end
        end
    end

    assign layer.busy  = busy;
    assign layer.done  = done;
    assign layer.y_out = y_q;
endmodule

// File: tb/tb_dense_layer_seq.sv
// Self-checking bench for dense_layer_seq: two small layers driven in parallel and compared
// every cycle against a pass-level arithmetic model; honours DENSE_SAT_EN like the design.
module tb_dense_layer_seq;
    localparam int N_IN        = 3;
    localparam int N_OUT       = 2;
    localparam int IN_W        = 8;
    localparam int WEIGHT_W    = 8;
    localparam int BIAS_W      = 8;
    localparam int OUT_W       = 8;
    localparam int LEAKY_SHIFT = 2;
    localparam int XW          = N_IN * IN_W;
    localparam int LAT         = N_OUT * (N_IN + 2) + 1;
    localparam int NDUT        = 2;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          load  = 1'b0;
    logic [XW-1:0] xVec  = '0;

    always #5 clk = ~clk;

    dense_layer_seq_if #(.N_IN(N_IN), .N_OUT(N_OUT), .IN_W(IN_W), .OUT_W(OUT_W)) busA ();
    dense_layer_seq_if #(.N_IN(N_IN), .N_OUT(N_OUT), .IN_W(IN_W), .OUT_W(OUT_W)) busB ();

    assign busA.load = load;
    assign busA.x_in = xVec;
    assign busB.load = load;
    assign busB.x_in = xVec;

    // Layer A: W=[[1,1,1],[-1,-1,-1]], b=[4,0].
    dense_layer_seq #(
        .N_IN(N_IN), .N_OUT(N_OUT), .IN_W(IN_W), .WEIGHT_W(WEIGHT_W), .BIAS_W(BIAS_W),
        .OUT_W(OUT_W), .LEAKY_SHIFT(LEAKY_SHIFT),
        .WEIGHT_INIT(48'hFFFFFF_010101), .BIAS_INIT(16'h0004)
    ) dutA (
        .clk   (clk),
        .reset (reset),
        .layer (busA)
    );

    // Layer B: W=[[127,127,127],[-128,5,-7]], b=[0,-3] to reach the output range limits.
    dense_layer_seq #(
        .N_IN(N_IN), .N_OUT(N_OUT), .IN_W(IN_W), .WEIGHT_W(WEIGHT_W), .BIAS_W(BIAS_W),
        .OUT_W(OUT_W), .LEAKY_SHIFT(LEAKY_SHIFT),
        .WEIGHT_INIT(48'hF90580_7F7F7F), .BIAS_INIT(16'hFD00)
    ) dutB (
        .clk   (clk),
        .reset (reset),
        .layer (busB)
    );

    int errors  = 0;
    int checks  = 0;
    bit checkEn = 1'b0;

    int wTab[NDUT][N_OUT][N_IN] = '{'{'{1, 1, 1}, '{-1, -1, -1}},
                                    '{'{127, 127, 127}, '{-128, 5, -7}}};
    int bTab[NDUT][N_OUT] = '{'{4, 0}, '{0, -3}};

    int busyLeft[NDUT]     = '{0, 0};
    int yExp[NDUT][N_OUT]  = '{'{0, 0}, '{0, 0}};
    int yPend[NDUT][N_OUT] = '{'{0, 0}, '{0, 0}};

    task automatic checkVal(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int narrowOut(input longint v);
        longint hi;
        longint m;
        hi = longint'(1) << (OUT_W - 1);
`ifdef DENSE_SAT_EN
        if (v > hi - 1) return int'(hi - 1);
        if (v < -hi) return int'(-hi);
        return int'(v);
`else
        m = v & ((hi << 1) - 1);
        if (m >= hi) m = m - (hi << 1);
        return int'(m);
`endif
    endfunction

    function automatic int xElem(input int i);
        return int'($signed(xVec[i*IN_W +: IN_W]));
    endfunction

    function automatic int neuron(input int k, input int j);
        longint acc;
        acc = bTab[k][j];
        for (int i = 0; i < N_IN; i++) begin
            acc = acc + longint'(xElem(i)) * wTab[k][j][i];
        end
        if (acc < 0) acc = acc >>> LEAKY_SHIFT;
        return narrowOut(acc);
    endfunction

    // Pass-level model: an accepted load fixes the whole result now and a countdown of LAT busy cycles.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NDUT; k++) begin
                busyLeft[k] <= 0;
                for (int j = 0; j < N_OUT; j++) yExp[k][j] <= 0;
            end
        end else begin
            for (int k = 0; k < NDUT; k++) begin
                if (busyLeft[k] == 0) begin
                    if (load) begin
                        busyLeft[k] <= LAT;
                        for (int j = 0; j < N_OUT; j++) yPend[k][j] <= neuron(k, j);
                    end
                end else begin
                    busyLeft[k] <= busyLeft[k] - 1;
                    if (busyLeft[k] == 2) begin
                        for (int j = 0; j < N_OUT; j++) yExp[k][j] <= yPend[k][j];
                    end
                end
            end
        end
    end

    task automatic checkDut(input int k, input logic busy, input logic done,
                            input logic [N_OUT*OUT_W-1:0] y);
        checkVal($sformatf("busy[%0d]", k), busy, busyLeft[k] != 0);
        checkVal($sformatf("done[%0d]", k), done, busyLeft[k] == 1);
        for (int j = 0; j < N_OUT; j++) begin
            checkVal($sformatf("y[%0d][%0d]", k, j), $signed(y[j*OUT_W +: OUT_W]), yExp[k][j]);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkDut(0, busA.busy, busA.done, busA.y_out);
            checkDut(1, busB.busy, busB.done, busB.y_out);
        end
    end

    task automatic applyStimulus(input bit ld, input int x0, input int x1, input int x2);
        @(posedge clk);
        #1;
        load = ld;
        xVec = {IN_W'(x2), IN_W'(x1), IN_W'(x0)};
    endtask

    task automatic waitDone(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!busA.done && lat <= 4 * LAT);
    endtask

    task automatic runPass(input int x0, input int x1, input int x2, output int lat);
        applyStimulus(1'b1, x0, x1, x2);
        @(posedge clk);
        #1;
        load = 1'b0;
        xVec = XW'($urandom());
        waitDone(lat);
    endtask

    task automatic checkOutput(input string tag, input logic [N_OUT*OUT_W-1:0] y,
                               input int y0, input int y1);
        checkVal({tag, "_y0"}, $signed(y[0 +: OUT_W]), y0);
        checkVal({tag, "_y1"}, $signed(y[OUT_W +: OUT_W]), y1);
    endtask

    initial begin
        int lat;
        int extraDones;
        int satY0;
        int satY1;
`ifdef DENSE_SAT_EN
        satY0 = 127;
        satY1 = -128;
`else
        satY0 = 3;
        satY1 = -33;
`endif
        @(posedge clk);
        checkEn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkVal("reset_busy", busA.busy, 0);
        checkVal("reset_y", busA.y_out, 0);
        reset = 1'b1;

        runPass(1, 2, 3, lat);
        checkVal("basic_latency", lat, 11);
        checkOutput("basic", busA.y_out, 10, -2);

        // Load in the first IDLE cycle after done; the previous result must hold until then.
        runPass(0, 0, 0, lat);
        checkVal("b2b_latency", lat, 11);
        checkOutput("b2b", busA.y_out, 4, 0);

        runPass(1, 0, 0, lat);
        checkOutput("leaky_edge", busA.y_out, 5, -1);

        runPass(127, 127, 127, lat);
        checkOutput("saturation", busB.y_out, satY0, satY1);

        applyStimulus(1'b1, 1, 2, 3);
        @(posedge clk);
        #1;
        load = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        load = 1'b1;
        xVec = {IN_W'(5), IN_W'(5), IN_W'(5)};
        @(posedge clk);
        #1;
        load = 1'b0;
        waitDone(lat);
        checkOutput("ignored_load", busA.y_out, 10, -2);
        extraDones = 0;
        repeat (15) begin
            @(negedge clk);
            if (busA.done) extraDones++;
        end
        checkVal("ignored_load_single_done", extraDones, 0);

        applyStimulus(1'b1, 9, 9, 9);
        @(posedge clk);
        #1;
        load = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkVal("midreset_busy", busA.busy, 0);
        checkVal("midreset_done", busA.done, 0);
        checkVal("midreset_y", busA.y_out, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        runPass(1, 2, 3, lat);
        checkVal("after_reset_latency", lat, 11);
        checkOutput("after_reset", busA.y_out, 10, -2);

        // Random traffic: loads at any time (many land while busy), x churning, rare resets.
        for (int c = 0; c < 500; c++) begin
            @(posedge clk);
            #1;
            load = ($urandom_range(0, 3) == 0);
            xVec = XW'($urandom());
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b0;
                @(posedge clk);
                #1;
                reset = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        load = 1'b0;
        repeat (LAT + 4) @(posedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
